// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Also holds the sequential-address helper used by the fetch unit.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES = 32'd4;

   // Wraps modulo 2^32 by construction.
   function automatic logic [31:0] next_seq_addr(input logic [31:0] addr);
      return addr + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and memory.
interface if_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues word fetches, holds a response across a
// freeze, redirects on taken branches and drops responses made stale by a redirect.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            branch_taken,
   input  logic [31:0]     branch_addr,
   if_fetch_unit_if.master imem,
   output logic            inst_valid,
   output logic [31:0]     PC,
   output logic [31:0]     Instruction
);

   fetch_state_t state_q, state_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  tgt_q, tgt_d;
   logic [31:0]  buf_q, buf_d;
   logic         accept_s;

   assign imem.imem_addr = req_addr_q;
   assign PC             = next_seq_addr(req_addr_q);
   assign accept_s       = inst_valid && !freeze && !branch_taken;

   // Outputs are presented combinationally so a held word costs no bubble.
   always_comb begin
      imem.imem_req = 1'b0;
      inst_valid    = 1'b0;
      Instruction   = NOP_INSTR;
      if (rst) begin
         imem.imem_req = 1'b0;
      end else begin
         case (state_q)
            REQ: begin
               imem.imem_req = 1'b1;
               inst_valid    = imem.imem_ready;
               Instruction   = imem.imem_ready ? imem.imem_rdata : NOP_INSTR;
            end
            HOLD: begin
               inst_valid  = 1'b1;
               Instruction = buf_q;
            end
            DISCARD: begin
               imem.imem_req = 1'b1;
            end
            default: begin
               imem.imem_req = 1'b0;
            end
         endcase
      end
   end

   // Next state and next fetch address; a branch always outranks a freeze.
   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      tgt_d      = tgt_q;
      buf_d      = buf_q;
      case (state_q)
         REQ: begin
            if (branch_taken) begin
               if (imem.imem_ready) begin
                  req_addr_d = branch_addr;
               end else begin
                  // In-flight address must stay put until the memory answers.
                  tgt_d   = branch_addr;
                  state_d = DISCARD;
               end
            end else if (accept_s) begin
               req_addr_d = next_seq_addr(req_addr_q);
            end else if (imem.imem_ready) begin
               buf_d   = imem.imem_rdata;
               state_d = HOLD;
            end else begin
               state_d = REQ;
            end
         end
         HOLD: begin
            if (branch_taken) begin
               req_addr_d = branch_addr;
               state_d    = REQ;
            end else if (!freeze) begin
               req_addr_d = next_seq_addr(req_addr_q);
               state_d    = REQ;
            end else begin
               state_d = HOLD;
            end
         end
         DISCARD: begin
            if (branch_taken) begin
               tgt_d = branch_addr;
               if (imem.imem_ready) begin
                  req_addr_d = branch_addr;
                  state_d    = REQ;
               end else begin
                  state_d = DISCARD;
               end
            end else if (imem.imem_ready) begin
               req_addr_d = tgt_q;
               state_d    = REQ;
            end else begin
               state_d = DISCARD;
            end
         end
         default: begin
            state_d = REQ;
         end
      endcase
   end

   // State registers with asynchronous reset back to the reset fetch address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= REQ;
         req_addr_q <= RESET_PC;
         tgt_q      <= 32'h0000_0000;
         buf_q      <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         tgt_q      <= tgt_d;
         buf_q      <= buf_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// freeze/branch/latency traffic checked against a program-order fetch model.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] instruction;

   if_fetch_unit_if imem_bus ();

   if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem         (imem_bus),
      .inst_valid   (inst_valid),
      .PC           (pc),
      .Instruction  (instruction)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Memory model state
   int mem_cnt, mem_lat, lat_lo, lat_hi;

   // Reference model state: address of the next instruction the pipeline should receive
   logic [31:0] exp_addr;
   bit          prev_hold, prev_wait;
   logic [31:0] prev_instr, prev_pc, prev_addr;
   int          idle, n_acc;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      exp_addr  = RESET_PC;
      prev_hold = 1'b0;
      prev_wait = 1'b0;
      idle      = 0;
   endtask

   task automatic mem_drive();
      logic [31:0] g;
      g = $urandom;
      if (imem_bus.imem_req) begin
         if (mem_cnt >= mem_lat) begin
            imem_bus.imem_ready = 1'b1;
            imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
            mem_cnt = 0;
            mem_lat = int'($urandom_range(lat_hi, lat_lo));
         end else begin
            imem_bus.imem_ready = 1'b0;
            imem_bus.imem_rdata = g;
            mem_cnt++;
         end
      end else begin
         imem_bus.imem_ready = 1'b0;
         imem_bus.imem_rdata = g;
         mem_cnt = 0;
      end
   endtask

   task automatic model_check();
      if (!branch_taken) begin
         if (!inst_valid)
            check_eq("instr_zero", instruction, 32'h0000_0000);
         if (prev_hold) begin
            check_eq("hold_valid", 32'(inst_valid), 32'd1);
            check_eq("hold_req", 32'(imem_bus.imem_req), 32'd0);
            check_eq("hold_instr", instruction, prev_instr);
            check_eq("hold_pc", pc, prev_pc);
         end
      end
      if (prev_wait) begin
         check_eq("wait_req", 32'(imem_bus.imem_req), 32'd1);
         check_eq("addr_stable", imem_bus.imem_addr, prev_addr);
      end
      if (inst_valid && !freeze && !branch_taken) begin
         check_eq("accept_instr", instruction, mem_word(exp_addr));
         check_eq("accept_pc", pc, exp_addr + 32'd4);
         exp_addr = exp_addr + 32'd4;
         idle = 0;
         n_acc++;
      end else begin
         idle++;
      end
      if (branch_taken)
         exp_addr = branch_addr;
      if (idle > 50) begin
         check_eq("progress", 32'(idle), 32'd0);
         idle = 0;
      end
      prev_hold  = inst_valid && freeze && !branch_taken;
      prev_instr = instruction;
      prev_pc    = pc;
      prev_wait  = imem_bus.imem_req && !imem_bus.imem_ready;
      prev_addr  = imem_bus.imem_addr;
   endtask

   task automatic step(input bit f, input bit b, input logic [31:0] ba);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      freeze       = f;
      branch_taken = b;
      branch_addr  = ba;
      mem_drive();
      @(negedge clk);
      model_check();
   endtask

   task automatic do_reset(input int lo, input int hi);
      @(negedge clk);
      rst          = 1'b1;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      imem_bus.imem_ready = 1'b0;
      @(negedge clk);
      lat_lo  = lo;
      lat_hi  = hi;
      mem_cnt = 0;
      mem_lat = lo;
      model_reset();
   endtask

   initial begin
      logic [31:0] t;
      rst          = 1'b1;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 32'h0000_0000;
      imem_bus.imem_ready = 1'b0;
      imem_bus.imem_rdata = 32'h0000_0000;
      n_acc = 0;
      lat_lo = 0; lat_hi = 0; mem_cnt = 0; mem_lat = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst_req", 32'(imem_bus.imem_req), 32'd0);
      check_eq("rst_valid", 32'(inst_valid), 32'd0);
      check_eq("rst_instr", instruction, 32'h0000_0000);
      check_eq("rst_pc", pc, RESET_PC + 32'd4);

      // Zero-wait memory: one instruction per cycle from the first request
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0);
         check_eq("zw_addr", imem_bus.imem_addr, RESET_PC + 32'(4 * i));
         check_eq("zw_valid", 32'(inst_valid), 32'd1);
         check_eq("zw_pc", pc, RESET_PC + 32'(4 * (i + 1)));
      end

      // Three-cycle memory, then a redirect while the next request is in flight
      do_reset(2, 2);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'h0);
         check_eq("lat3_addr", imem_bus.imem_addr, RESET_PC);
         check_eq("lat3_valid", 32'(inst_valid), (i == 2) ? 32'd1 : 32'd0);
      end
      step(1'b0, 1'b1, 32'h0000_0100);
      check_eq("br_inflight_addr", imem_bus.imem_addr, RESET_PC + 32'd4);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 32'h0);
         check_eq("discard_addr", imem_bus.imem_addr, RESET_PC + 32'd4);
         check_eq("discard_valid", 32'(inst_valid), 32'd0);
      end
      step(1'b0, 1'b0, 32'h0);
      check_eq("redirect_addr", imem_bus.imem_addr, 32'h0000_0100);
      check_eq("redirect_req", 32'(imem_bus.imem_req), 32'd1);

      // Address wrap at the top of the address space
      do_reset(0, 0);
      step(1'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      check_eq("wrap_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
      check_eq("wrap_pc", pc, 32'h0000_0000);
      step(1'b0, 1'b0, 32'h0);
      check_eq("wrap_addr_zero", imem_bus.imem_addr, 32'h0000_0000);

      // Asynchronous reset in the middle of a pending request
      lat_lo = 3; lat_hi = 3;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      check_eq("pre_arst_req", 32'(imem_bus.imem_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_req", 32'(imem_bus.imem_req), 32'd0);
      check_eq("arst_valid", 32'(inst_valid), 32'd0);
      check_eq("arst_pc", pc, RESET_PC + 32'd4);
      imem_bus.imem_ready = 1'b0;
      mem_cnt = 0; mem_lat = 3;
      model_reset();
      step(1'b0, 1'b0, 32'h0);
      check_eq("arst_restart_addr", imem_bus.imem_addr, RESET_PC);
      check_eq("arst_restart_req", 32'(imem_bus.imem_req), 32'd1);

      // Randomized freeze / branch / latency traffic
      do_reset(0, 3);
      n_acc = 0;
      for (int i = 0; i < 3000; i++) begin
         t = $urandom;
         t[1:0] = 2'b00;
         if ($urandom_range(3, 0) == 0)
            t = 32'hFFFF_FFF0 | (t & 32'h0000_000C);
         step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 8, t);
      end
      check_eq("random_progress", 32'(n_acc > 100), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
